// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_mem_pkg
// Brief  : Shared types and constants for the MIPS memory bus bridge.
// Rev    : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

   // Bridge controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } bridge_state_t;

   // Access size encoding, identical to the datapath MemExt field
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b11;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   // Any size with bit 1 clear is a word access (00 and 01 both mean word)
   function automatic logic is_word(input logic [1:0] size);
      return ~size[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_align
// Brief  : Combinational lane steering: byte enables, store replication,
//          load right-alignment and misalignment detection.
// Rev    : 1.0  initial release
// ============================================================================
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  ofs_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   // Decode size and byte offset into lane controls; word access is the default
   always_comb begin
      be_o         = 4'hF;
      wdata_o      = wdata_i;
      rdata_o      = rdata_i;
      misaligned_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << ofs_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {24'h000000, rdata_i[{ofs_i, 3'b000} +: 8]};
         end
         SZ_HALF: begin
            // Only ofs_i[1] selects the half; an odd offset is flagged and never used
            be_o         = 4'b0011 << ofs_i;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {16'h0000, rdata_i[{ofs_i[1], 4'b0000} +: 16]};
            misaligned_o = ofs_i[0];
         end
         default: begin
            misaligned_o = (ofs_i != 2'b00);
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_bridge
// Brief  : Multicycle bridge from the MIPS datapath memory port to an
//          Avalon-MM style bus. One bus transfer per request, stall until done.
// Rev    : 1.0  initial release
// ============================================================================
module mem_bus_bridge
   import mips_mem_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 1023
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        stall,
   output logic        err_misaligned,
   output logic        err_timeout,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   // Counter only needs to reach WAIT_LIMIT-1: the abort fires in that cycle
   localparam int unsigned c_cnt_w = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
   localparam logic [c_cnt_w-1:0] c_limit_last =
      c_cnt_w'((WAIT_LIMIT == 0) ? 0 : (WAIT_LIMIT - 1));

   bridge_state_t        state_q, state_d;
   logic [c_cnt_w-1:0]   wait_cnt_q;
   logic [1:0]           size_q;
   logic [1:0]           ofs_q;
   logic [31:0]          rd_data_q;
   logic [31:0]          avm_address_q;
   logic                 avm_read_q;
   logic                 avm_write_q;
   logic [31:0]          avm_writedata_q;
   logic [3:0]           avm_byteenable_q;
   logic                 err_mis_q;
   logic                 err_to_q;

   logic                 w_req_any;
   logic                 w_req_one;
   logic                 w_timeout;
   logic [1:0]           w_la_size;
   logic [1:0]           w_la_ofs;
   logic [3:0]           w_la_be;
   logic [31:0]          w_la_wdata;
   logic [31:0]          w_la_rdata;
   logic                 w_la_mis;

   assign w_req_any = req_read | req_write;
   assign w_req_one = req_read ^ req_write;
   assign w_timeout = (WAIT_LIMIT != 0) && avm_waitrequest && (wait_cnt_q == c_limit_last);

   // One aligner serves both phases: request-side lanes in IDLE, read alignment in BUS
   assign w_la_size = (state_q == IDLE) ? req_size      : size_q;
   assign w_la_ofs  = (state_q == IDLE) ? req_addr[1:0] : ofs_q;

   mem_lane_align u_lane_align (
      .size_i       (w_la_size),
      .ofs_i        (w_la_ofs),
      .wdata_i      (req_wdata),
      .rdata_i      (avm_readdata),
      .be_o         (w_la_be),
      .wdata_o      (w_la_wdata),
      .rdata_o      (w_la_rdata),
      .misaligned_o (w_la_mis)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; simultaneous read and write is rejected like a misalignment
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (w_req_any) begin
               if (!w_req_one || w_la_mis) begin
                  state_d = DONE;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            if (!avm_waitrequest || w_timeout) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus command, wait counter, load data and error holding registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt_q       <= '0;
         size_q           <= SZ_WORD;
         ofs_q            <= 2'b00;
         rd_data_q        <= 32'h0;
         avm_address_q    <= 32'h0;
         avm_read_q       <= 1'b0;
         avm_write_q      <= 1'b0;
         avm_writedata_q  <= 32'h0;
         avm_byteenable_q <= 4'h0;
         err_mis_q        <= 1'b0;
         err_to_q         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (state_d == BUS) begin
                  wait_cnt_q       <= '0;
                  size_q           <= req_size;
                  ofs_q            <= req_addr[1:0];
                  avm_address_q    <= {req_addr[31:2], 2'b00};
                  avm_read_q       <= req_read;
                  avm_write_q      <= req_write;
                  avm_writedata_q  <= w_la_wdata;
                  avm_byteenable_q <= w_la_be;
               end else if (state_d == DONE) begin
                  err_mis_q <= 1'b1;
               end
            end
            BUS: begin
               if (!avm_waitrequest) begin
                  if (avm_read_q) begin
                     rd_data_q <= w_la_rdata;
                  end
                  avm_read_q  <= 1'b0;
                  avm_write_q <= 1'b0;
               end else if (w_timeout) begin
                  avm_read_q  <= 1'b0;
                  avm_write_q <= 1'b0;
                  err_to_q    <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            default: begin
               err_mis_q <= 1'b0;
               err_to_q  <= 1'b0;
            end
         endcase
      end
   end

   // Status outputs decoded from the current state
   always_comb begin
      done           = (state_q == DONE);
      stall          = ((state_q == IDLE) && w_req_any) || (state_q == BUS);
      err_misaligned = (state_q == DONE) && err_mis_q;
      err_timeout    = (state_q == DONE) && err_to_q;
   end

   assign rd_data        = rd_data_q;
   assign avm_address    = avm_address_q;
   assign avm_read       = avm_read_q;
   assign avm_write      = avm_write_q;
   assign avm_writedata  = avm_writedata_q;
   assign avm_byteenable = avm_byteenable_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_bus_bridge
// Brief  : Self-checking bench for mem_bus_bridge with a behavioural lane
//          model and a simple waitrequest-driven bus slave.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_bus_bridge;

   localparam logic [1:0] T_WORD = 2'b00;
   localparam logic [1:0] T_HALF = 2'b11;
   localparam logic [1:0] T_BYTE = 2'b10;

   logic        clk;
   logic        rst0, rst4;
   logic        req_read, req_write;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   logic [31:0] rd0, rd4, adr0, adr4, wd0, wd4;
   logic        dn0, dn4, st0, st4, em0, em4, et0, et4, ar0, ar4, aw0, aw4;
   logic [3:0]  be0, be4;

   logic        sel4;
   logic [31:0] o_rd_data, o_avm_address, o_avm_writedata;
   logic        o_done, o_stall, o_err_mis, o_err_to, o_avm_read, o_avm_write;
   logic [3:0]  o_avm_be;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_rd [2];

   mem_bus_bridge dut (
      .clk(clk), .reset(rst0),
      .req_read(req_read), .req_write(req_write), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rd_data(rd0), .done(dn0), .stall(st0),
      .err_misaligned(em0), .err_timeout(et0),
      .avm_address(adr0), .avm_read(ar0), .avm_write(aw0),
      .avm_writedata(wd0), .avm_byteenable(be0),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
   );

   mem_bus_bridge #(.WAIT_LIMIT(4)) dut4 (
      .clk(clk), .reset(rst4),
      .req_read(req_read), .req_write(req_write), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rd_data(rd4), .done(dn4), .stall(st4),
      .err_misaligned(em4), .err_timeout(et4),
      .avm_address(adr4), .avm_read(ar4), .avm_write(aw4),
      .avm_writedata(wd4), .avm_byteenable(be4),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe whichever bridge is currently under test
   always_comb begin
      o_rd_data       = sel4 ? rd4  : rd0;
      o_done          = sel4 ? dn4  : dn0;
      o_stall         = sel4 ? st4  : st0;
      o_err_mis       = sel4 ? em4  : em0;
      o_err_to        = sel4 ? et4  : et0;
      o_avm_address   = sel4 ? adr4 : adr0;
      o_avm_read      = sel4 ? ar4  : ar0;
      o_avm_write     = sel4 ? aw4  : aw0;
      o_avm_writedata = sel4 ? wd4  : wd0;
      o_avm_be        = sel4 ? be4  : be0;
   end

   // ---------------- behavioural reference model ----------------
   function automatic int m_nbytes(input logic [1:0] sz);
      if (sz[1] == 1'b0) return 4;
      else if (sz == T_HALF) return 2;
      else return 1;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      int nb;
      logic [7:0] v;
      nb = m_nbytes(sz);
      v  = 8'(((1 << nb) - 1) << (a % 4));
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      int nb;
      nb = m_nbytes(sz);
      r  = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic [31:0] a,
                                           input logic [31:0] bus);
      logic [63:0] mask;
      int nb;
      nb   = m_nbytes(sz);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      return 32'((64'(bus) >> (8 * (a % 4))) & mask);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One request from the datapath side, with a slave that holds waitrequest for nwait cycles
   task automatic xfer(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] bus_rd, input int nwait);
      int  limit, nb, exp_done, exp_strb, k, strb, wcnt;
      bit  mis, tmo, got;
      limit    = sel4 ? 4 : 1023;
      nb       = m_nbytes(sz);
      mis      = (rd && wr) || ((addr % nb) != 0);
      tmo      = !mis && (nwait >= limit);
      exp_strb = mis ? 0 : (tmo ? limit : nwait + 1);
      exp_done = mis ? 2 : (tmo ? limit + 2 : nwait + 3);
      req_read = rd; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd;
      avm_readdata = bus_rd; avm_waitrequest = 1'b0;
      k = 1; strb = 0; wcnt = 0; got = 1'b0;
      while (!got && k < 2000) begin
         @(negedge clk);
         k++;
         if (o_done) begin
            got = 1'b1;
            chk("done_cycle", k, exp_done);
            chk("err_misaligned", o_err_mis, mis);
            chk("err_timeout", o_err_to, tmo);
            chk("stall_in_done", o_stall, 1'b0);
            chk("strobe_in_done", {o_avm_read, o_avm_write}, 2'b00);
         end else begin
            chk("stall_busy", o_stall, 1'b1);
            if (o_avm_read || o_avm_write) begin
               strb++;
               chk("avm_address", o_avm_address, {addr[31:2], 2'b00});
               chk("avm_byteenable", o_avm_be, m_be(sz, addr));
               chk("strobe_kind", {o_avm_read, o_avm_write}, {rd, wr});
               if (wr) chk("avm_writedata", o_avm_writedata, m_wdata(sz, wd));
               avm_waitrequest = (wcnt < nwait);
               wcnt++;
            end
         end
      end
      n_tests++;
      assert (got) else begin
         n_fail++;
         $error("FAIL done_wait observed=no_done expected=done");
      end
      chk("strobe_cycles", strb, exp_strb);
      req_read = 1'b0; req_write = 1'b0; avm_waitrequest = 1'b0;
      if (rd && !mis && !tmo) exp_rd[sel4] = m_rdata(sz, addr, bus_rd);
      @(negedge clk);
      chk("rd_data", o_rd_data, exp_rd[sel4]);
      chk("done_one_cycle", o_done, 1'b0);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      sel4 = 1'b0; rst0 = 1'b0; rst4 = 1'b0;
      req_read = 1'b0; req_write = 1'b0; req_size = T_WORD;
      req_addr = '0; req_wdata = '0;
      avm_waitrequest = 1'b0; avm_readdata = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (3) @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_rd_data", o_rd_data, 32'h0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_errs", {o_err_mis, o_err_to}, 2'b00);
      chk("rst_strobes", {o_avm_read, o_avm_write}, 2'b00);
      chk("rst_address", o_avm_address, 32'h0);
      chk("rst_writedata", o_avm_writedata, 32'h0);
      chk("rst_be", o_avm_be, 4'h0);

      // Word load, zero wait
      xfer(1, 0, T_WORD, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
      // Byte store to top lane
      xfer(0, 1, T_BYTE, 32'h0000_2003, 32'h0000_00A5, 32'h0, 0);
      // Half load of upper half with five wait cycles
      xfer(1, 0, T_HALF, 32'h0000_3002, 32'h0, 32'h8001_7F7F, 5);
      // Misaligned half load and word store
      xfer(1, 0, T_HALF, 32'h0000_3001, 32'h0, 32'h1234_5678, 0);
      xfer(0, 1, T_WORD, 32'h0000_3002, 32'h5555_AAAA, 32'h0, 0);
      // Both strobes requested at once
      xfer(1, 1, T_WORD, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF, 0);
      // Byte load and half store at other lanes
      xfer(1, 0, T_BYTE, 32'h0000_5001, 32'h0, 32'h11C3_2233, 1);
      xfer(0, 1, T_HALF, 32'h0000_5000, 32'hABCD_1234, 32'h0, 2);

      // Reset during the second bus cycle of a store
      req_write = 1'b1; req_size = T_WORD; req_addr = 32'h0000_4000; req_wdata = 32'hCAFE_F00D;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("rst_mid_bus1", o_avm_write, 1'b1);
      avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("rst_mid_bus2", o_avm_write, 1'b1);
      rst0 = 1'b0; req_write = 1'b0;
      @(negedge clk);
      chk("rst_mid_write", o_avm_write, 1'b0);
      chk("rst_mid_stall", o_stall, 1'b0);
      chk("rst_mid_done", o_done, 1'b0);
      rst0 = 1'b1; avm_waitrequest = 1'b0; exp_rd[0] = '0;
      @(negedge clk);
      chk("post_rst_done", o_done, 1'b0);
      xfer(1, 0, T_WORD, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 1);

      // Randomised traffic against the lane model
      for (int i = 0; i < 40; i++) begin
         bit          r, w;
         logic [1:0]  sz;
         logic [31:0] a;
         r  = ($urandom % 2) == 0;
         w  = !r;
         if (($urandom % 8) == 0) begin r = 1'b1; w = 1'b1; end
         sz = 2'($urandom % 4);
         a  = $urandom;
         if (($urandom % 2) == 0) a[1:0] = (sz == T_HALF) ? {a[1], 1'b0} : ((sz[1] == 1'b0) ? 2'b00 : a[1:0]);
         xfer(r, w, sz, a, $urandom, $urandom, int'($urandom % 4));
      end

      // Timeout on the short-limit bridge
      rst0 = 1'b0; sel4 = 1'b1; rst4 = 1'b1; exp_rd[1] = '0;
      @(negedge clk);
      xfer(1, 0, T_WORD, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 10);
      xfer(1, 0, T_BYTE, 32'h0000_6002, 32'h0, 32'h00EE_0000, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
